vec_mul_fp_seq: RTL

Sequential, lane-shared successor of the elementwise minifloat vector multiplier. Accepts one pair of `length`-element minifloat vectors through a valid/ready handshake. Multiplies them `lanes` elements per cycle using a bank of `mul_fp6` instances. Presents the full signed fixed-point product vector on a held output buffer. Sits between the MX block unpacker and the dot-product/accumulate stage, where area matters more than single-cycle throughput.

---
 rtl/vec_mul_pkg.sv | 15 +
 rtl/mul_fp6.sv | 40 ++++
 rtl/vec_mul_fp_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vec_mul_pkg.sv
// Shared types and sizing helpers for the sequential minifloat vector multiplier.
// Consumers size their product buses with prd_w() so they always agree.
package vec_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int prd_w(input int exp_width, input int man_width);
    return 2 * ((1 << exp_width) + man_width + 2);
  endfunction

endpackage

// File: rtl/mul_fp6.sv
// Minifloat element multiplier: both operands expanded to signed fixed point,
// then multiplied exactly into a double-width signed product.
module mul_fp6
  import vec_mul_pkg::*;
#(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int fi_width  = man_width + 2,
  localparam int hw        = (1 << exp_width) + fi_width,
  localparam int prd_width = prd_w(exp_width, man_width)
) (
  input  logic [bit_width-1:0]        i_a,
  input  logic [bit_width-1:0]        i_b,
  output logic signed [prd_width-1:0] o_prd
);

  // Subnormals (exp 0) share the scale of exp 1, with no hidden bit.
  function automatic logic [hw-1:0] to_fx(input logic [bit_width-1:0] x);
    logic [exp_width-1:0] e;
    logic [exp_width-1:0] sh;
    logic                 hid;
    logic [hw-1:0]        mag;
    e   = x[bit_width-2 -: exp_width];
    hid = |e;
    sh  = hid ? e - 1'b1 : '0;
    mag = hw'({hid, x[man_width-1:0]}) << sh;
    return x[bit_width-1] ? -mag : mag;
  endfunction

  logic [hw-1:0]               fa, fb;
  logic signed [prd_width-1:0] xa, xb;

  assign fa    = to_fx(i_a);
  assign fb    = to_fx(i_b);
  assign xa    = {{hw{fa[hw-1]}}, fa};
  assign xb    = {{hw{fb[hw-1]}}, fb};
  assign o_prd = xa * xb;

endmodule

// File: rtl/vec_mul_fp_seq.sv
// Lane-shared minifloat vector multiplier: one vector pair per handshake,
// lanes products per cycle, full product vector held until consumed.
module vec_mul_fp_seq
  import vec_mul_pkg::*;
#(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int length    = 32,
  parameter int lanes     = 8,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int fi_width  = man_width + 2,
  localparam int prd_width = prd_w(exp_width, man_width),
  localparam int n_chunk   = length / lanes
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [length-1:0][bit_width-1:0]  i_vec_a,
  input  logic [length-1:0][bit_width-1:0]  i_vec_b,
  input  logic                              i_neg,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic [length-1:0][prd_width-1:0]  o_prd,
  output logic                              o_valid,
  input  logic                              i_ready
);

  localparam int cw = (n_chunk > 1) ? $clog2(n_chunk) : 1;
  localparam logic [cw-1:0] last = cw'(n_chunk - 1);

  if (length % lanes != 0) begin : g_chk
    $error("vec_mul_fp_seq: length must be a multiple of lanes");
  end

  state_t state, state_d;
  logic [cw-1:0] cnt;
  logic [length-1:0][bit_width-1:0] a_q, b_q;
  logic neg_q;
  logic accept;
  logic [lanes-1:0][bit_width-1:0] la, lb;
  logic [lanes-1:0][prd_width-1:0] lp, lr;

  assign accept = i_valid & o_ready;

  always_comb begin
    state_d = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt == last) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        o_ready = i_ready;
        if (i_ready) state_d = i_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt   <= '0;
        a_q   <= i_vec_a;
        b_q   <= i_vec_b;
        neg_q <= i_neg;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    la = '0;
    lb = '0;
    for (int k = 0; k < n_chunk; k++) begin
      if (cnt == cw'(k)) begin
        for (int j = 0; j < lanes; j++) begin
          la[j] = a_q[k*lanes+j];
          lb[j] = b_q[k*lanes+j];
        end
      end
    end
  end

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    mul_fp6 #(
      .exp_width(exp_width),
      .man_width(man_width)
    ) u_mul (
      .i_a  (la[j]),
      .i_b  (lb[j]),
      .o_prd(lp[j])
    );
    assign lr[j] = neg_q ? -lp[j] : lp[j];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_prd <= '0;
    end else if (state == CALC) begin
      for (int k = 0; k < n_chunk; k++) begin
        if (cnt == cw'(k)) begin
          for (int j = 0; j < lanes; j++) begin
            o_prd[k*lanes+j] <= lr[j];
          end
        end
      end
    end
  end

endmodule
